// File: rtl/circuit_stim_sequencer.sv
// Exhaustive stimulus sequencer: drives every N_IN-bit vector to a small circuit,
// captures its output into a truth table, then compares that table against a golden one.
module circuit_stim_sequencer #(
   parameter int N_IN          = 3,
   parameter int SETTLE_CYCLES = 25,
   parameter int CNT_W         = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [2**N_IN-1:0]    expected,
   input  logic                  dut_out,
   output logic [N_IN-1:0]       dut_in,
   output logic                  busy,
   output logic                  done,
   output logic [2**N_IN-1:0]    truth_table,
   output logic                  pass,
   output logic [N_IN:0]         mismatch_cnt
);

   localparam int NV = 2**N_IN;
   localparam logic [N_IN-1:0]  LAST_IDX    = '1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      SAMPLE,
      CHECK
   } state_t;

   state_t            state, next_state;
   logic [N_IN-1:0]   idx;
   logic [CNT_W-1:0]  cnt;
   logic              pass_q;
   logic [N_IN:0]     mismatch_q;
   logic [NV-1:0]     diff;
   logic [N_IN:0]     cmp_cnt;
   logic              cmp_pass;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start && !abort) next_state = APPLY;
         APPLY:   next_state = abort ? IDLE : SETTLE;
         SETTLE: begin
            if (abort)                    next_state = IDLE;
            else if (cnt == SETTLE_LAST)  next_state = SAMPLE;
         end
         SAMPLE: begin
            if (abort)                    next_state = IDLE;
            else if (idx == LAST_IDX)     next_state = CHECK;
            else                          next_state = APPLY;
         end
         CHECK:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      diff    = truth_table ^ expected;
      cmp_cnt = '0;
      for (int unsigned i = 0; i < NV; i++)
         cmp_cnt = cmp_cnt + {{N_IN{1'b0}}, diff[i]};
      cmp_pass = (diff == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx         <= '0;
         cnt         <= '0;
         dut_in      <= '0;
         truth_table <= '0;
         pass_q      <= 1'b0;
         mismatch_q  <= '0;
      end else if (state != IDLE && abort) begin
         // Abort keeps the partial truth table but releases the circuit inputs.
         dut_in <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  idx         <= '0;
                  truth_table <= '0;
                  pass_q      <= 1'b0;
                  mismatch_q  <= '0;
               end
            end
            APPLY: begin
               dut_in <= idx;
               cnt    <= '0;
            end
            SETTLE: cnt <= cnt + 1'b1;
            SAMPLE: begin
               truth_table[idx] <= dut_out;
               if (idx != LAST_IDX) idx <= idx + 1'b1;
            end
            CHECK: begin
               pass_q     <= cmp_pass;
               mismatch_q <= cmp_cnt;
               dut_in     <= '0;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);
   assign done = (state == CHECK) && !abort;
   // Result is live during the done cycle, then held from the register until the next start.
   assign pass         = done ? cmp_pass : pass_q;
   assign mismatch_cnt = done ? cmp_cnt  : mismatch_q;

endmodule

// File: tb/tb_circuit_stim_sequencer.sv
// Self-checking bench for circuit_stim_sequencer: a random truth function stands in for the
// circuit under test and a behavioural model predicts timing, captured table and verdict.
module tb_circuit_stim_sequencer;

   localparam int N  = 3;
   localparam int S  = 2;
   localparam int CW = 3;
   localparam int NV = 1 << N;
   localparam int T  = NV * (S + 2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [NV-1:0] expected = '0;
   logic          dut_out;
   logic [N-1:0]  dut_in;
   logic          busy, done, pass;
   logic [NV-1:0] truth_table;
   logic [N:0]    mismatch_cnt;

   logic [NV-1:0] func = 8'h96;
   bit            dly_mode = 1'b0;
   logic [S-1:0]  dly = '0;

   int checks = 0;
   int errors = 0;

   circuit_stim_sequencer #(.N_IN(N), .SETTLE_CYCLES(S), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
      .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done),
      .truth_table(truth_table), .pass(pass), .mismatch_cnt(mismatch_cnt)
   );

   always #5 clk = ~clk;

   // Circuit under test: either combinational lookup or the same lookup delayed by S cycles.
   always @(posedge clk) dly <= {dly[S-2:0], func[dut_in]};
   assign dut_out = dly_mode ? dly[S-1] : func[dut_in];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sweep(input logic [NV-1:0] f, input logic [NV-1:0] e, input bit m, input bit hold);
      int unsigned exp_in;
      @(negedge clk);
      func = f; expected = e; dly_mode = m; start = 1'b1;
      for (int c = 0; c <= T; c++) begin
         @(negedge clk);
         if (c == 0 && !hold) start = 1'b0;
         exp_in = (c == 0) ? 0 : (c - 1) / (S + 2);
         check("busy", 32'(busy), 32'(c < T));
         check("done", 32'(done), 32'(c == T));
         check("dut_in", 32'(dut_in), exp_in);
         if (c == T) begin
            check("truth_table", 32'(truth_table), 32'(f));
            check("pass", 32'(pass), 32'(f == e));
            check("mismatch_cnt", 32'(mismatch_cnt), 32'($countones(f ^ e)));
         end
         if (!hold && c == 1)     expected = ~e;
         if (!hold && c == T - 1) expected = e;
      end
      @(negedge clk);
      start = 1'b0;
      check("post_done", 32'(done), 32'd0);
      check("post_busy", 32'(busy), 32'd0);
      check("post_dut_in", 32'(dut_in), 32'd0);
      check("post_pass", 32'(pass), 32'(f == e));
      check("post_mismatch", 32'(mismatch_cnt), 32'($countones(f ^ e)));
      @(negedge clk);
      check("no_restart", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [NV-1:0] f, e;
      int            done_seen;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dut_in", 32'(dut_in), 32'd0);
      check("rst_tt", 32'(truth_table), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_mismatch", 32'(mismatch_cnt), 32'd0);
      rst_n = 1'b1;

      // Parity circuit, matching and off-by-one golden tables
      sweep(8'h96, 8'h96, 1'b0, 1'b0);
      sweep(8'h96, 8'h97, 1'b0, 1'b0);
      // Output delayed by the full settle time
      sweep(8'h96, 8'h96, 1'b1, 1'b0);

      // Random truth functions and golden tables
      for (int k = 0; k < 6; k++) begin
         f = NV'($urandom);
         e = ($urandom_range(0, 1) == 1) ? f : (f ^ NV'($urandom));
         sweep(f, e, bit'($urandom_range(0, 1)), 1'b0);
      end

      // start held through a whole sweep
      f = NV'($urandom);
      sweep(f, f, 1'b0, 1'b1);

      // start and abort together in IDLE
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      check("sa_busy", 32'(busy), 32'd0);
      check("sa_dut_in", 32'(dut_in), 32'd0);
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("sa_busy2", 32'(busy), 32'd0);

      // Abort in the APPLY cycle right after the third SAMPLE
      f = NV'($urandom);
      @(negedge clk);
      func = f; expected = f; dly_mode = 1'b0; start = 1'b1;
      for (int c = 0; c <= 3 * (S + 2); c++) begin
         @(negedge clk);
         if (c == 0) start = 1'b0;
         if (c == 3 * (S + 2)) abort = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0;
      check("ab_busy", 32'(busy), 32'd0);
      check("ab_done", 32'(done), 32'd0);
      check("ab_dut_in", 32'(dut_in), 32'd0);
      check("ab_tt", 32'(truth_table), 32'(f) & 32'h7);
      check("ab_pass", 32'(pass), 32'd0);
      check("ab_mismatch", 32'(mismatch_cnt), 32'd0);
      done_seen = 0;
      for (int c = 0; c < T + 4; c++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("ab_quiet", 32'(done_seen), 32'd0);

      // Reset in the middle of SETTLE
      f = NV'($urandom);
      @(negedge clk);
      func = f; expected = ~f; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_done", 32'(done), 32'd0);
      check("mr_dut_in", 32'(dut_in), 32'd0);
      check("mr_tt", 32'(truth_table), 32'd0);
      check("mr_pass", 32'(pass), 32'd0);
      check("mr_mismatch", 32'(mismatch_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sweep(f, f, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
